simd_wave_sequencer: RTL
========================

Name: simd_wave_sequencer

Overview:
- Per-SIMD control stage directly upstream of the per-lane register files and ALUs.
- After `start`, steps one thread block through the kernel one instruction at a time.
- For each instruction it walks every (wave, wave-cycle) slice of the block and drives `simd_state`, `wave_id`, `curr_wave_cycle` and a per-lane active mask to all lanes.
- Handles the instruction-fetch and memory-wait handshakes, branch PC update and kernel return.

Parameters:
- WAVE_SIZE, 32, threads per wave.
- LANE_WIDTH, 16, SIMD lanes; threads processed per wave-cycle.
- PC_WIDTH, 8, instruction address width.
- CYC_W, 1, `curr_wave_cycle` width; must equal max(1, clog2(ceil(WAVE_SIZE/LANE_WIDTH))).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  launch block; sampled only in IDLE.
- block_dim  in  32  threads in block; latched on accepted start.
- fetch_req  out  1  instruction fetch request.
- fetch_pc  out  PC_WIDTH  fetch address; equals pc.
- fetch_valid  in  1  fetched instruction available to decoder.
- dec_ret  in  1  decoded RET; valid in DECODE.
- dec_mem  in  1  decoded load/store; valid in DECODE.
- dec_branch  in  1  decoded taken branch; valid in DECODE.
- branch_target  in  PC_WIDTH  branch destination; valid in DECODE.
- mem_req  out  1  memory access request for the current slice.
- mem_ready  in  1  memory access complete.
- simd_state  out  3  IDLE=000 FETCH=001 DECODE=010 REQUEST=011 WAIT=100 EXECUTE=101 UPDATE=110 DONE=111.
- wave_id  out  32 signed  current wave index.
- curr_wave_cycle  out  CYC_W  current slice within the wave.
- active_mask  out  LANE_WIDTH  bit i set when that lane's thread index is < block_dim.
- pc  out  PC_WIDTH  current program counter.
- busy  out  1  high in every state except IDLE.
- done  out  1  high for exactly one cycle, while in DONE.

Behaviour:
- Reset values: state IDLE; pc, wave_id, curr_wave_cycle, active_mask, fetch_req, mem_req, done, busy all 0; latched dim 0; mem/ret/branch flags cleared.
- Derived values:
  - NCYC = ceil(WAVE_SIZE/LANE_WIDTH).
  - NWAVES = ceil(dim/WAVE_SIZE), computed from the latched dim with 33-bit arithmetic so it cannot overflow.
- IDLE:
  - start=1 latches block_dim, sets pc=0, wave_id=0, curr_wave_cycle=0.
  - Next state is FETCH, or DONE if block_dim==0.
  - start is ignored in every other state.
- FETCH: fetch_req=1 while waiting. On fetch_valid=1, go to DECODE; fetch_req drops the same edge. Unbounded wait.
- DECODE (1 cycle): latch dec_mem, dec_ret, dec_branch, branch_target. wave_id=0, curr_wave_cycle=0. Next REQUEST.
- REQUEST (1 cycle): register files read operands. Next WAIT if mem flag set, else EXECUTE.
- WAIT:
  - mem_req=1 until mem_ready.
  - On mem_ready=1 go to EXECUTE.
  - mem_ready arriving in the same cycle WAIT is entered is accepted (1-cycle WAIT).
- EXECUTE (1 cycle): next UPDATE.
- UPDATE (1 cycle): register files write back. Slice advance:
  - If curr_wave_cycle < NCYC-1: increment curr_wave_cycle, go to REQUEST.
  - Else, if wave_id < NWAVES-1: wave_id+1, curr_wave_cycle=0, go to REQUEST.
  - Else (last slice):
    - ret flag set: go to DONE.
    - Otherwise pc = branch flag ? branch_target : pc+1 (wraps modulo 2^PC_WIDTH); go to FETCH.
- DONE: done=1 for one cycle, then IDLE. pc and wave_id hold; mask 0.
- active_mask: registered, updated whenever wave_id/curr_wave_cycle change. Bit i = ((wave_id*WAVE_SIZE + curr_wave_cycle*LANE_WIDTH + i) < dim); 0 outside REQUEST..UPDATE.
  - A partial final wave masks its tail lanes.
  - A slice with no valid threads is still sequenced, with mask=0.
- A RET on a non-final slice has no effect until the last slice completes.
- rst asserted in any state, including WAIT/FETCH mid-handshake, restores reset values on the next edge. In-flight fetch_valid/mem_ready are then ignored.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset then start, block_dim=32, fetch_valid and mem_ready tied 1, one non-mem instruction with dec_ret=1:
  - state sequence 001,010,011,101,110,011,101,110,111,000;
  - curr_wave_cycle 0 then 1; wave_id 0; active_mask 0xFFFF both slices;
  - done pulses once.
- block_dim=40, non-mem RET: waves 0 and 1 sequenced. Masks per slice are 0xFFFF, 0xFFFF, 0x00FF, 0x0000.
- Memory instruction with mem_ready delayed 3 cycles: WAIT held 3 cycles with mem_req=1, then EXECUTE; mem_req low afterwards.
- Instruction at pc=5 with dec_branch=1, branch_target=0x20: after the final UPDATE, pc=0x20 and fetch_pc=0x20 in FETCH. Separately, pc=0xFF non-branch wraps to 0x00.
- block_dim=0 with start: IDLE → DONE → IDLE, done one cycle, no FETCH.
- rst pulsed during WAIT with mem_req=1: next cycle state=000, mem_req=0, pc=0. A later mem_ready=1 has no effect; start while busy is ignored.

Source files
------------

// File: rtl/simd_wave_sequencer.sv
// simd_wave_sequencer
//   Per-SIMD control stage that sits directly upstream of the per-lane
//   register files and ALUs. After a start it steps one thread block through
//   the kernel one instruction at a time. For every instruction it walks each
//   (wave, wave-cycle) slice of the block and broadcasts the sequencer state,
//   the slice coordinates and the per-lane active mask to all lanes.
//
// Ports
//   clk, rst          clock and synchronous active-high reset
//   start, block_dim  block launch (sampled only in IDLE) and thread count
//   fetch_req/_pc     instruction fetch handshake towards the I-side
//   fetch_valid       fetched instruction available to the decoder
//   dec_*             decoded RET / load-store / taken-branch flags, target
//   mem_req/ready     memory access handshake for the current slice
//   simd_state        IDLE=0 FETCH=1 DECODE=2 REQUEST=3 WAIT=4 EXECUTE=5
//                     UPDATE=6 DONE=7
//   wave_id           current wave index
//   curr_wave_cycle   current slice inside the wave
//   active_mask       lane i set when its thread index is below block_dim
//   pc                program counter (fetch_pc mirrors it)
//   busy, done        busy outside IDLE; done is a one-cycle pulse in DONE
module simd_wave_sequencer #(
  parameter int WAVE_SIZE  = 32,
  parameter int LANE_WIDTH = 16,
  parameter int PC_WIDTH   = 8,
  parameter int CYC_W      = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [31:0]           block_dim,
  output logic                  fetch_req,
  output logic [PC_WIDTH-1:0]   fetch_pc,
  input  logic                  fetch_valid,
  input  logic                  dec_ret,
  input  logic                  dec_mem,
  input  logic                  dec_branch,
  input  logic [PC_WIDTH-1:0]   branch_target,
  output logic                  mem_req,
  input  logic                  mem_ready,
  output logic [2:0]            simd_state,
  output logic signed [31:0]    wave_id,
  output logic [CYC_W-1:0]      curr_wave_cycle,
  output logic [LANE_WIDTH-1:0] active_mask,
  output logic [PC_WIDTH-1:0]   pc,
  output logic                  busy,
  output logic                  done
);

  localparam int NCYC = (WAVE_SIZE + LANE_WIDTH - 1) / LANE_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_FETCH   = 3'b001,
    S_DECODE  = 3'b010,
    S_REQUEST = 3'b011,
    S_WAIT    = 3'b100,
    S_EXECUTE = 3'b101,
    S_UPDATE  = 3'b110,
    S_DONE    = 3'b111
  } state_t;

  state_t                  state_q;
  logic [PC_WIDTH-1:0]     pc_q;
  logic signed [31:0]      waveId_q;
  logic [CYC_W-1:0]        currCyc_q;
  logic [LANE_WIDTH-1:0]   activeMask_q;
  logic                    fetchReq_q;
  logic                    memReq_q;
  logic                    done_q;
  logic                    busy_q;
  logic [31:0]             dim_q;
  logic                    memFlag_q;
  logic                    retFlag_q;
  logic                    branchFlag_q;
  logic [PC_WIDTH-1:0]     branchTarget_q;

  logic signed [31:0]      wave_d;
  logic [CYC_W-1:0]        cyc_d;
  logic [LANE_WIDTH-1:0]   mask_d;
  logic [LANE_WIDTH-1:0]   firstMask;
  logic                    sliceLast;
  logic [32:0]             nWaves;
  logic                    cycLast;
  logic                    waveLast;

  // Lane i of slice (wave, cyc) owns thread wave*WAVE_SIZE + cyc*LANE_WIDTH + i.
  // 48-bit arithmetic keeps the thread index exact for any 32-bit wave index.
  function automatic logic [LANE_WIDTH-1:0] sliceMask(input logic [31:0]      wave,
                                                      input logic [CYC_W-1:0] cyc,
                                                      input logic [31:0]      dim);
    logic [LANE_WIDTH-1:0] m;
    logic [47:0]           base;
    base = 48'(wave) * 48'(WAVE_SIZE) + 48'(cyc) * 48'(LANE_WIDTH);
    for (int i = 0; i < LANE_WIDTH; i++) begin
      m[i] = (base + 48'(i)) < {16'b0, dim};
    end
    return m;
  endfunction

  // Wave count uses a 33-bit sum so a block_dim near 2^32 cannot wrap.
  assign nWaves    = ({1'b0, dim_q} + 33'(WAVE_SIZE - 1)) / 33'(WAVE_SIZE);
  assign cycLast   = (currCyc_q == CYC_W'(NCYC - 1));
  assign waveLast  = (({1'b0, waveId_q}) + 33'd1) >= nWaves;
  assign firstMask = sliceMask(32'd0, '0, dim_q);

  // Coordinates and mask of the slice that follows the current one.
  always_comb begin
    wave_d    = waveId_q;
    cyc_d     = currCyc_q;
    sliceLast = 1'b0;
    if (!cycLast) begin
      cyc_d = currCyc_q + CYC_W'(1);
    end else if (!waveLast) begin
      wave_d = waveId_q + 32'sd1;
      cyc_d  = '0;
    end else begin
      sliceLast = 1'b1;
    end
    mask_d = sliceMask(wave_d, cyc_d, dim_q);
  end

  // Sequencer FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      pc_q           <= '0;
      waveId_q       <= '0;
      currCyc_q      <= '0;
      activeMask_q   <= '0;
      fetchReq_q     <= 1'b0;
      memReq_q       <= 1'b0;
      done_q         <= 1'b0;
      busy_q         <= 1'b0;
      dim_q          <= '0;
      memFlag_q      <= 1'b0;
      retFlag_q      <= 1'b0;
      branchFlag_q   <= 1'b0;
      branchTarget_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            dim_q     <= block_dim;
            pc_q      <= '0;
            waveId_q  <= '0;
            currCyc_q <= '0;
            busy_q    <= 1'b1;
            if (block_dim == 32'd0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q    <= S_FETCH;
              fetchReq_q <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          if (fetch_valid) begin
            state_q    <= S_DECODE;
            fetchReq_q <= 1'b0;
          end
        end
        S_DECODE: begin
          memFlag_q      <= dec_mem;
          retFlag_q      <= dec_ret;
          branchFlag_q   <= dec_branch;
          branchTarget_q <= branch_target;
          waveId_q       <= '0;
          currCyc_q      <= '0;
          activeMask_q   <= firstMask;
          state_q        <= S_REQUEST;
        end
        S_REQUEST: begin
          if (memFlag_q) begin
            state_q  <= S_WAIT;
            memReq_q <= 1'b1;
          end else begin
            state_q <= S_EXECUTE;
          end
        end
        S_WAIT: begin
          if (mem_ready) begin
            state_q  <= S_EXECUTE;
            memReq_q <= 1'b0;
          end
        end
        S_EXECUTE: begin
          state_q <= S_UPDATE;
        end
        S_UPDATE: begin
          if (!sliceLast) begin
            waveId_q     <= wave_d;
            currCyc_q    <= cyc_d;
            activeMask_q <= mask_d;
            state_q      <= S_REQUEST;
          end else begin
            activeMask_q <= '0;
            if (retFlag_q) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              pc_q       <= branchFlag_q ? branchTarget_q : pc_q + PC_WIDTH'(1);
              state_q    <= S_FETCH;
              fetchReq_q <= 1'b1;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign fetch_req       = fetchReq_q;
  assign fetch_pc        = pc_q;
  assign mem_req         = memReq_q;
  assign simd_state      = state_q;
  assign wave_id         = waveId_q;
  assign curr_wave_cycle = currCyc_q;
  assign active_mask     = activeMask_q;
  assign pc              = pc_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule
